snake_head_ctrl: RTL and testbench

Movement controller that owns the snake head position and drives the body stack directly downstream. On every move tick it steps the head one grid cell in the current direction and checks the board bounds. It presents the new head coordinate with a one-cycle push (grow) or pop (shift) strobe, so the stack always holds the body trail. It also tracks snake length and the run/dead game state.

---
 rtl/snake_head_ctrl.sv | 176 +++++++++++++++++
 tb/tb_snake_head_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/snake_head_ctrl.sv
// Snake head movement controller: steps the head on each tick, checks bounds and hits,
// and strobes push/pop into the body stack. Define SNAKE_WRAP_EN to wrap at board edges.
module snake_head_ctrl #(
  parameter int STEP    = 20,
  parameter int X_MIN   = 0,
  parameter int X_MAX   = 620,
  parameter int Y_MIN   = 0,
  parameter int Y_MAX   = 460,
  parameter int START_X = 320,
  parameter int START_Y = 240,
  parameter int MAX_LEN = 26
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        grow,
  input  logic        hit,
  output logic [10:0] head_x,
  output logic [10:0] head_y,
  output logic        push,
  output logic        pop,
  output logic [4:0]  length,
  output logic        running,
  output logic        game_over
);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DEAD} state_t;
  // Encoding chosen so that the opposite direction is dir ^ 1.
  typedef enum logic [1:0] {D_UP, D_DOWN, D_LEFT, D_RIGHT} dir_t;

  localparam logic signed [11:0] STEP_S = 12'(STEP);
  localparam logic signed [11:0] XMIN_S = 12'(X_MIN);
  localparam logic signed [11:0] XMAX_S = 12'(X_MAX);
  localparam logic signed [11:0] YMIN_S = 12'(Y_MIN);
  localparam logic signed [11:0] YMAX_S = 12'(Y_MAX);

  state_t      state_q, state_d;
  dir_t        dir_q, dir_d;
  logic [10:0] head_x_q, head_x_d, head_y_q, head_y_d;
  logic [4:0]  length_q, length_d;
  logic        push_q, push_d, pop_q, pop_d;
  logic        running_q, running_d, game_over_q, game_over_d;
  logic        grow_q, grow_d;

  logic signed [11:0] nxt_x, nxt_y;
  logic               wall_hit;
  logic               req_valid;
  dir_t               req_dir;

  // Next head position and bounds check for the current direction.
  always_comb begin
    nxt_x = $signed({1'b0, head_x_q});
    nxt_y = $signed({1'b0, head_y_q});
    case (dir_q)
      D_UP:    nxt_y = nxt_y - STEP_S;
      D_DOWN:  nxt_y = nxt_y + STEP_S;
      D_LEFT:  nxt_x = nxt_x - STEP_S;
      default: nxt_x = nxt_x + STEP_S;
    endcase
`ifdef SNAKE_WRAP_EN
    wall_hit = 1'b0;
    if (nxt_x > XMAX_S)      nxt_x = XMIN_S;
    else if (nxt_x < XMIN_S) nxt_x = XMAX_S;
    if (nxt_y > YMAX_S)      nxt_y = YMIN_S;
    else if (nxt_y < YMIN_S) nxt_y = YMAX_S;
`else
    wall_hit = (nxt_x < XMIN_S) || (nxt_x > XMAX_S) ||
               (nxt_y < YMIN_S) || (nxt_y > YMAX_S);
`endif
  end

  always_comb begin
    req_valid = btn_up | btn_down | btn_left | btn_right;
    if (btn_up)        req_dir = D_UP;
    else if (btn_down) req_dir = D_DOWN;
    else if (btn_left) req_dir = D_LEFT;
    else               req_dir = D_RIGHT;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT:  state_d = S_RUN;
      S_RUN:   if (hit || (tick && wall_hit)) state_d = S_DEAD;
      default: if (start) state_d = S_INIT;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    head_x_d    = head_x_q;
    head_y_d    = head_y_q;
    length_d    = length_q;
    dir_d       = dir_q;
    grow_d      = grow_q;
    push_d      = 1'b0;
    pop_d       = 1'b0;
    running_d   = (state_d == S_RUN);
    game_over_d = (state_d == S_DEAD);
    case (state_q)
      S_RUN: begin
        if (req_valid && (req_dir != dir_t'(dir_q ^ 2'b01))) dir_d = req_dir;
        if (tick) grow_d = 1'b0;
        else if (grow) grow_d = 1'b1;
        if (tick && !hit && !wall_hit) begin
          head_x_d = nxt_x[10:0];
          head_y_d = nxt_y[10:0];
          if ((grow_q || grow) && (length_q < 5'(MAX_LEN))) begin
            push_d   = 1'b1;
            length_d = length_q + 5'd1;
          end else begin
            pop_d = 1'b1;
          end
        end
      end
      S_INIT: ;
      default: begin
        // The INIT load happens on the entry edge so push coincides with the start head.
        if (start) begin
          head_x_d = 11'(START_X);
          head_y_d = 11'(START_Y);
          dir_d    = D_RIGHT;
          length_d = 5'd1;
          grow_d   = 1'b0;
          push_d   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_x_q    <= 11'(START_X);
      head_y_q    <= 11'(START_Y);
      length_q    <= '0;
      dir_q       <= D_RIGHT;
      grow_q      <= 1'b0;
      push_q      <= 1'b0;
      pop_q       <= 1'b0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      head_x_q    <= head_x_d;
      head_y_q    <= head_y_d;
      length_q    <= length_d;
      dir_q       <= dir_d;
      grow_q      <= grow_d;
      push_q      <= push_d;
      pop_q       <= pop_d;
      running_q   <= running_d;
      game_over_q <= game_over_d;
    end
  end

  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign length    = length_q;
  assign push      = push_q;
  assign pop       = pop_q;
  assign running   = running_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Randomized self-checking bench for snake_head_ctrl against a game-rule reference model.
// Honours SNAKE_WRAP_EN the same way as the design.
module tb_snake_head_ctrl;

  logic        clk, reset, start, tick, grow, hit;
  logic        btn_up, btn_down, btn_left, btn_right;
  logic [10:0] head_x, head_y;
  logic        push, pop, running, game_over;
  logic [4:0]  length;

  snake_head_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .tick(tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .grow(grow), .hit(hit), .head_x(head_x), .head_y(head_y),
    .push(push), .pop(pop), .length(length), .running(running), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Reference model: game phase plus head position and velocity in pixels.
  typedef enum {P_IDLE, P_INIT, P_RUN, P_DEAD} phase_t;
  phase_t m_ph;
  int m_x, m_y, m_dx, m_dy, m_len;
  bit m_grow, m_push, m_pop;

  task automatic model_reset();
    m_ph = P_IDLE; m_x = 320; m_y = 240; m_dx = 20; m_dy = 0;
    m_len = 0; m_grow = 0; m_push = 0; m_pop = 0;
  endtask

  task automatic model_step();
    int nx, ny, rdx, rdy;
    bit ok;
    m_push = 0; m_pop = 0;
    case (m_ph)
      P_IDLE, P_DEAD: if (start) begin
        m_ph = P_INIT; m_x = 320; m_y = 240; m_dx = 20; m_dy = 0;
        m_len = 1; m_grow = 0; m_push = 1;
      end
      P_INIT: m_ph = P_RUN;
      P_RUN: begin
        if (tick && !hit) begin
          nx = m_x + m_dx; ny = m_y + m_dy;
`ifdef SNAKE_WRAP_EN
          if (nx > 620) nx = 0; else if (nx < 0) nx = 620;
          if (ny > 460) ny = 0; else if (ny < 0) ny = 460;
          ok = 1;
`else
          ok = (nx >= 0 && nx <= 620 && ny >= 0 && ny <= 460);
`endif
          if (!ok) m_ph = P_DEAD;
          else begin
            m_x = nx; m_y = ny;
            if ((m_grow || grow) && m_len < 26) begin m_push = 1; m_len++; end
            else m_pop = 1;
          end
        end
        if (tick) m_grow = 0; else if (grow) m_grow = 1;
        if (hit) m_ph = P_DEAD;
        if (btn_up || btn_down || btn_left || btn_right) begin
          if (btn_up)        begin rdx = 0;   rdy = -20; end
          else if (btn_down) begin rdx = 0;   rdy = 20;  end
          else if (btn_left) begin rdx = -20; rdy = 0;   end
          else               begin rdx = 20;  rdy = 0;   end
          if (!(rdx == -m_dx && rdy == -m_dy)) begin m_dx = rdx; m_dy = rdy; end
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_outputs(input string ctx);
    chk({ctx, ".head_x"}, int'(head_x), m_x);
    chk({ctx, ".head_y"}, int'(head_y), m_y);
    chk({ctx, ".length"}, int'(length), m_len);
    chk({ctx, ".push"}, int'(push), int'(m_push));
    chk({ctx, ".pop"}, int'(pop), int'(m_pop));
    chk({ctx, ".running"}, int'(running), int'(m_ph == P_RUN));
    chk({ctx, ".game_over"}, int'(game_over), int'(m_ph == P_DEAD));
  endtask

  task automatic cyc(input string ctx);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(ctx);
  endtask

  task automatic clear_inputs();
    start = 0; tick = 0; grow = 0; hit = 0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
  endtask

  task automatic set_btn(input int d);
    btn_up = (d == 0); btn_down = (d == 1); btn_left = (d == 2); btn_right = (d == 3);
  endtask

  initial begin
    clear_inputs();
    reset = 1;
    model_reset();
    #2 check_outputs("reset");
    #10 reset = 0;

    start = 1; cyc("start"); start = 0;
    cyc("init"); cyc("run0");

    tick = 1;
    repeat (3) cyc("tick3");
    tick = 0;

    // Square path (up,left,down,right) keeps the head on the board while growing.
    for (int i = 0; i < 28; i++) begin
      set_btn(i % 4 == 0 ? 0 : i % 4 == 1 ? 2 : i % 4 == 2 ? 1 : 3);
      cyc("turn");
      set_btn(-1); grow = 1; tick = 1;
      cyc("grow_tick");
      grow = 0; tick = 0;
    end
    chk("len_max", int'(length), 26);

    set_btn(2); cyc("opp_btn");
    tick = 1; cyc("opp_tick"); tick = 0;
    set_btn(0); cyc("up_btn");
    tick = 1; cyc("up_tick"); tick = 0;
    set_btn(3); cyc("right_btn"); set_btn(-1);

    for (int i = 0; i < 20; i++) begin
      tick = 1; cyc("wall"); tick = 0; cyc("wall_gap");
    end

    start = 1; cyc("restart"); start = 0;
    cyc("restart_init");
    tick = 1; hit = 1; cyc("hit_tick"); tick = 0; hit = 0;
    cyc("after_hit");

    start = 1; cyc("start2"); start = 0;
    cyc("init2");
    grow = 1; tick = 1; cyc("grow_before_reset"); grow = 0; tick = 0;
    #2 reset = 1;
    #1 model_reset(); check_outputs("async_reset");
    #2 reset = 0;

    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 29) == 0);
      tick      = ($urandom_range(0, 2) == 0);
      grow      = ($urandom_range(0, 5) == 0);
      hit       = ($urandom_range(0, 99) == 0);
      btn_up    = ($urandom_range(0, 7) == 0);
      btn_down  = ($urandom_range(0, 7) == 0);
      btn_left  = ($urandom_range(0, 7) == 0);
      btn_right = ($urandom_range(0, 7) == 0);
      cyc("rand");
      chk("push_pop_excl", int'(push & pop), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
